// File: rtl/tinyqv_lsu_if.sv
// Memory-side bus of the load/store unit: one request channel, one read-response channel.
interface tinyqv_lsu_if #(
  parameter int ADDR_BITS = 28
) ();
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [3:0]           mem_be;
  logic [31:0]          mem_wdata;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/tinyqv_lsu.sv
// Load/store unit: collects nibble-serial store data, issues one 32-bit bus access,
// and replays aligned load data to the core in the 8-clock counter window.
//
// state   | meaning
// IDLE    | no access in flight
// REQ     | request presented, waiting for mem_req_ready
// WAIT_RD | load accepted, waiting for mem_rvalid
// HOLD    | read word captured, waiting for counter wrap
// DELIVER | replaying rbuf nibbles, counter 0..7
module tinyqv_lsu #(
  parameter int ADDR_BITS = 28
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [2:0]           counter,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           mem_op,
  input  logic                 address_ready,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [3:0]           store_nibble,
  output logic [3:0]           load_data_out,
  output logic                 load_data_ready,
  output logic                 busy,
  tinyqv_lsu_if.master         mem
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_RD = 3'd2,
    HOLD    = 3'd3,
    DELIVER = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          sdata;
  logic [31:0]          sword_q;
  logic [31:0]          rbuf;
  logic [ADDR_BITS-3:0] addr_q;
  logic [1:0]           size_q;
  logic [1:0]           off_q;
  logic                 we_q;

  logic                 req_valid;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [3:0]           req_be;
  logic [31:0]          req_wdata;
  logic [3:0]           ld_out;
  logic                 ld_ready;
  logic                 start;
  logic [31:0]          sdata_next;

  // Unsigned flag only matters to the core's sign extension.
  logic unused_ok;
  assign unused_ok = mem_op[2];

  assign sdata_next = {store_nibble, sdata[31:4]};
  assign start      = address_ready && (is_load || is_store);

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = 4'b0000;
    req_wdata = 32'h0;
    ld_out    = 4'h0;
    ld_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        req_we    = we_q;
        req_addr  = {addr_q, 2'b00};
        case (size_q)
          2'b00:   req_be = 4'b0001 << off_q;
          2'b01:   req_be = off_q[1] ? 4'b1100 : 4'b0011;
          default: req_be = 4'b1111;
        endcase
        case (size_q)
          2'b00:   req_wdata = {4{sword_q[7:0]}};
          2'b01:   req_wdata = {2{sword_q[15:0]}};
          default: req_wdata = sword_q;
        endcase
        if (mem.mem_req_ready) state_d = we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem.mem_rvalid) state_d = (counter == 3'd7) ? DELIVER : HOLD;
      end
      HOLD: begin
        if (counter == 3'd7) state_d = DELIVER;
      end
      DELIVER: begin
        ld_ready = 1'b1;
        ld_out   = rbuf[3:0];
        if (counter == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Store word is snapshotted at issue so a stalled write keeps stable data
  // even if the core keeps clocking is_store.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sdata   <= 32'h0;
      sword_q <= 32'h0;
      rbuf    <= 32'h0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (is_store) sdata <= sdata_next;
      if (state_q == IDLE && start) begin
        addr_q  <= addr_in[ADDR_BITS-1:2];
        size_q  <= mem_op[1:0];
        off_q   <= addr_in[1:0];
        we_q    <= is_store;
        sword_q <= sdata_next;
      end
      if (state_q == WAIT_RD && mem.mem_rvalid)
        rbuf <= mem.mem_rdata >> {off_q, 3'b000};
      else if (state_q == DELIVER)
        rbuf <= rbuf >> 4;
    end
  end

  assign busy              = (state_q != IDLE);
  assign load_data_out     = ld_out;
  assign load_data_ready   = ld_ready;
  assign mem.mem_req_valid = req_valid;
  assign mem.mem_we        = req_we;
  assign mem.mem_addr      = req_addr;
  assign mem.mem_be        = req_be;
  assign mem.mem_wdata     = req_wdata;

endmodule

// File: tb/tb_tinyqv_lsu.sv
// Bench for tinyqv_lsu: directed scenarios plus random loads/stores against a
// transaction-level model of byte enables, write lanes and delivered nibbles.
module tb_tinyqv_lsu;
  localparam int AB = 28;

  logic          clk = 1'b0;
  logic          rstn;
  logic [2:0]    counter;
  logic          is_load, is_store, address_ready;
  logic [2:0]    mem_op;
  logic [AB-1:0] addr_in;
  logic [3:0]    store_nibble;
  logic [3:0]    load_data_out;
  logic          load_data_ready, busy;
  int            tests = 0;
  int            fails = 0;

  tinyqv_lsu_if #(.ADDR_BITS(AB)) mem_bus ();

  tinyqv_lsu #(.ADDR_BITS(AB)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .counter        (counter),
    .is_load        (is_load),
    .is_store       (is_store),
    .mem_op         (mem_op),
    .address_ready  (address_ready),
    .addr_in        (addr_in),
    .store_nibble   (store_nibble),
    .load_data_out  (load_data_out),
    .load_data_ready(load_data_ready),
    .busy           (busy),
    .mem            (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the core counter ticks once per clock.
  task automatic step();
    @(posedge clk);
    #1;
    counter = counter + 3'd1;
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'(1 << off);
      2'd1:    return (off >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] rs2);
    case (sz)
      2'd0:    return {4{rs2[7:0]}};
      2'd1:    return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  task automatic chk_req(input logic [AB-1:0] addr, input logic [1:0] sz, input logic we,
                         input logic [31:0] rs2);
    chk("req_valid", mem_bus.mem_req_valid, 1);
    chk("req_addr", mem_bus.mem_addr, {addr[AB-1:2], 2'b00});
    chk("req_be", mem_bus.mem_be, exp_be(sz, addr[1:0]));
    chk("req_we", mem_bus.mem_we, we);
    if (we) chk("req_wdata", mem_bus.mem_wdata, exp_wdata(sz, rs2));
    chk("req_busy", busy, 1);
  endtask

  task automatic do_load(input logic [AB-1:0] addr, input logic [1:0] sz,
                         input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                         input bit poke);
    logic [31:0] val;
    while (counter != 3'd7) step();
    chk("ld_idle_busy", busy, 0);
    is_load = 1; address_ready = 1; addr_in = addr;
    mem_op = {1'($urandom_range(0, 1)), sz};
    step();
    is_load = 0; address_ready = 0;
    for (int i = 0; i < rdy_dly; i++) begin
      chk_req(addr, sz, 1'b0, 32'h0);
      if (poke) begin
        address_ready = 1; is_load = 1; addr_in = ~addr;
      end
      step();
      address_ready = 0; is_load = 0;
    end
    chk_req(addr, sz, 1'b0, 32'h0);
    mem_bus.mem_req_ready = 1;
    step();
    mem_bus.mem_req_ready = 0;
    chk("wait_valid", mem_bus.mem_req_valid, 0);
    for (int i = 0; i < rv_dly; i++) begin
      chk("wait_ldr", load_data_ready, 0);
      chk("wait_busy", busy, 1);
      step();
    end
    mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = rdata;
    step();
    mem_bus.mem_rvalid = 0;
    while (counter != 3'd0) begin
      chk("hold_ldr", load_data_ready, 0);
      chk("hold_busy", busy, 1);
      mem_bus.mem_rvalid = 1'($urandom_range(0, 1));
      mem_bus.mem_rdata  = $urandom;
      step();
    end
    val = rdata >> (8 * addr[1:0]);
    for (int k = 0; k < 8; k++) begin
      chk("dlv_ldr", load_data_ready, 1);
      chk("dlv_nibble", load_data_out, val[4*k +: 4]);
      mem_bus.mem_rvalid = 1'($urandom_range(0, 1));
      mem_bus.mem_rdata  = $urandom;
      step();
    end
    mem_bus.mem_rvalid = 0;
    chk("ld_end_busy", busy, 0);
    chk("ld_end_ldr", load_data_ready, 0);
  endtask

  task automatic do_store(input logic [AB-1:0] addr, input logic [1:0] sz,
                          input logic [31:0] rs2, input int rdy_dly);
    while (counter != 3'd0) step();
    for (int c = 0; c < 8; c++) begin
      is_store = 1; store_nibble = rs2[4*c +: 4];
      if (c == 7) begin
        address_ready = 1; addr_in = addr;
        mem_op = {1'($urandom_range(0, 1)), sz};
      end
      step();
    end
    is_store = 0; address_ready = 0; store_nibble = 0;
    for (int i = 0; i < rdy_dly; i++) begin
      chk_req(addr, sz, 1'b1, rs2);
      step();
    end
    chk_req(addr, sz, 1'b1, rs2);
    mem_bus.mem_req_ready = 1;
    step();
    mem_bus.mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("st_end_busy", busy, 0);
      chk("st_end_valid", mem_bus.mem_req_valid, 0);
      chk("st_end_ldr", load_data_ready, 0);
      step();
    end
  endtask

  initial begin
    rstn = 0; counter = 3'd0; is_load = 0; is_store = 0; address_ready = 0;
    mem_op = 3'd0; addr_in = '0; store_nibble = 4'h0;
    mem_bus.mem_req_ready = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = 32'h0;
    #1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", mem_bus.mem_req_valid, 0);
    chk("rst_ldr", load_data_ready, 0);
    chk("rst_ldo", load_data_out, 0);
    chk("rst_be", mem_bus.mem_be, 0);
    rstn = 1;
    step();

    do_load(28'h100, 2'd2, 32'h89ABCDEF, 0, 0, 0);
    do_load(28'h203, 2'd0, 32'h7F001122, 0, 0, 0);
    do_store(28'h302, 2'd1, 32'h0000BEEF, 0);
    do_load(28'h444, 2'd2, 32'h12345678, 5, 0, 1);
    do_store(28'h501, 2'd0, 32'hCAFEF00D, 5);
    do_load(28'h600, 2'd2, 32'hA5A55A5A, 0, 6, 0);
    do_load(28'h602, 2'd1, 32'hDEAD1234, 0, 1, 0);

    // Reset while waiting for read data; the late response must be dropped.
    while (counter != 3'd7) step();
    is_load = 1; address_ready = 1; addr_in = 28'h700; mem_op = 3'd2;
    step();
    is_load = 0; address_ready = 0;
    mem_bus.mem_req_ready = 1;
    step();
    mem_bus.mem_req_ready = 0;
    chk("wrd_busy", busy, 1);
    rstn = 0;
    step();
    rstn = 1;
    chk("rst2_busy", busy, 0);
    chk("rst2_valid", mem_bus.mem_req_valid, 0);
    chk("rst2_ldr", load_data_ready, 0);
    mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'hFFFFFFFF;
    step();
    mem_bus.mem_rvalid = 0;
    for (int i = 0; i < 16; i++) begin
      chk("late_rv_ldr", load_data_ready, 0);
      chk("late_rv_busy", busy, 0);
      step();
    end

    for (int n = 0; n < 30; n++) begin
      logic [AB-1:0] a;
      logic [1:0]    sz;
      a  = AB'($urandom);
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0)
        do_store(a, sz, $urandom, $urandom_range(0, 4));
      else
        do_load(a, sz, $urandom, $urandom_range(0, 4), $urandom_range(0, 9),
                1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tinyqv_lsu.md
Name: tinyqv_lsu

Overview:
Load/store unit directly downstream of the nibble-serial core. It captures the store data nibble stream and the address/op at `address_ready`, then issues one 32-bit-bus memory transaction. For loads it captures the read word, aligns it and replays it to the core nibble-serially, locked to the 8-clock `counter` window, with `load_data_ready` asserted. The core performs sign extension; this block only aligns lanes.

Parameters:
ADDR_BITS, 28, width of byte address on core and memory side

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
counter  in  3  core sub-cycle counter, increments every clock
is_load  in  1  active instruction is a load
is_store  in  1  active instruction is a store
mem_op  in  3  funct3: [1:0] size (00 byte, 01 half, 10 word), [2] unsigned (ignored here)
address_ready  in  1  addr_in valid for active load/store (counter==7)
addr_in  in  ADDR_BITS  byte address from core
store_nibble  in  4  core store data, nibble `counter` of rs2
load_data_out  out  4  aligned load data, nibble `counter`
load_data_ready  out  1  load_data_out valid for this clock
busy  out  1  LSU not IDLE; decode must issue stalls while high
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request this clock
mem_we  out  1  1 = write
mem_addr  out  ADDR_BITS  word-aligned address (low 2 bits zero)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned write data
mem_rvalid  in  1  read data valid (single clock)
mem_rdata  in  32  read word

Behaviour:
- Store shift register `sdata[31:0]`:
  - Every clock while `is_store`: `sdata <= {store_nibble, sdata[31:4]}`.
  - At the `counter==7` clock the shift includes that clock's nibble, so the full rs2 value is present at the next edge.
- States: IDLE, REQ, WAIT_RD, HOLD, DELIVER.
- IDLE:
  - On `address_ready && (is_load||is_store)` latch: addr, size, `we = is_store`, `off = addr_in[1:0]`.
  - Go to REQ.
  - `address_ready` while not IDLE is ignored; no state change.
- REQ:
  - `mem_req_valid = 1`; `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` are stable until accepted.
  - Acceptance is `mem_req_valid && mem_req_ready`. On acceptance: store goes to IDLE (posted write); load goes to WAIT_RD.
- mem_be:
  - byte: `1 << off`.
  - half: `4'b0011 << off` (`off[0]` is ignored, treated as 0).
  - word: `4'b1111`.
  - Misaligned accesses are not trapped.
- mem_wdata:
  - byte: `{4{sdata[7:0]}}`.
  - half: `{2{sdata[15:0]}}`.
  - word: `sdata`.
- WAIT_RD:
  - On `mem_rvalid` capture `rbuf <= mem_rdata >> (8*off)`; zeros are shifted in.
  - If `counter==7` that same clock, go to DELIVER; otherwise go to HOLD.
- HOLD: when `counter==7`, go to DELIVER. Delivery therefore always starts at `counter==0`.
- DELIVER (exactly 8 clocks, counter 0..7):
  - `load_data_ready = 1`; `load_data_out = rbuf[3:0]`.
  - `rbuf <= rbuf >> 4` each clock.
  - At `counter==7` go to IDLE.
- Outputs:
  - `busy = (state != IDLE)`.
  - `load_data_ready` and `load_data_out` are 0 outside DELIVER.
  - `mem_req_valid` is 0 outside REQ.
- Latency:
  - Minimum load, with `mem_req_ready` high and `mem_rvalid` the clock after acceptance: data delivered in the first counter window after the response.
  - Never in the same window as `address_ready`.
- Reset (`rstn` low at any edge):
  - state goes to IDLE; all outputs 0; `sdata` and `rbuf` cleared.
  - An in-flight request is dropped.
- A `mem_rvalid` arriving in any state other than WAIT_RD is ignored, including a late response after reset.
- Simultaneous `mem_req_ready` and `mem_rvalid` in REQ: `rvalid` is ignored. The memory must respond at least 1 clock after acceptance.

Test Plan:
- Word load: addr 0x100 at counter 7, ready=1, rvalid 1 clk later with 0x89ABCDEF -> one DELIVER window starting at counter 0, nibbles F,E,D,C,B,A,9,8; `load_data_ready` high exactly 8 clks; `mem_be`=1111, `mem_addr`=0x100.
- Byte load offset 3: addr 0x203, rdata 0x7F001122 -> `mem_addr`=0x200, `mem_be`=1000, delivered nibbles F,7,0,0,0,0,0,0.
- Half store offset 2: rs2=0x0000BEEF streamed over counters 0..7, addr 0x302 -> `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xBEEFBEEF; returns to IDLE on accept with no `load_data_ready`.
- Back-pressure: `mem_req_ready` low 5 clks -> `mem_req_valid`, `mem_addr`, `mem_be` held constant; `busy`=1 throughout; one request accepted.
- `rvalid` on `counter==7` clock, and `rvalid` on `counter==2` -> the first delivers starting at the next counter 0; the second holds in HOLD until after counter 7, then delivers.
- Reset in WAIT_RD, then `mem_rvalid`: `rstn` low 1 clk -> `busy`=0 and `mem_req_valid`=0; a subsequent `mem_rvalid` produces no `load_data_ready`.
